// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// ---------------------------------------------------------------------------
// Shares the register file's single write port between two writeback
// requesters using round-robin arbitration with valid/ready handshakes. It
// also runs a sequenced clear sweep that writes zero to every register, one
// address per cycle. All write-port outputs come straight from flops.
//
// Parameters:
//   DATA_W       width of write data
//   ADDR_W       width of register address; the sweep covers 2**ADDR_W entries
//   ZERO_PROTECT when non-zero, accepted writes to address 0 are consumed
//                without raising regWrite
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   req0_*      requester 0: valid/addr/data in, ready out (combinational)
//   req1_*      requester 1: valid/addr/data in, ready out (combinational)
//   clr_start   level request to start a clear sweep, sampled in IDLE
//   busy        clear sweep in progress (its last write still on the port)
//   regWrite    register file write strobe
//   Rw          register file write address
//   W           register file write data
//   grant_id    requester whose data is on W; 0 for clear writes
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int ZERO_PROTECT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              clr_start,
    output logic              busy,
    output logic              regWrite,
    output logic [ADDR_W-1:0] Rw,
    output logic [DATA_W-1:0] W,
    output logic              grant_id
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        state_r;
    logic              prio_r;
    logic [ADDR_W-1:0] clr_cnt_r;

    logic              grant_any_s;
    logic              grant_sel_s;
    logic [ADDR_W-1:0] grant_addr_s;
    logic [DATA_W-1:0] grant_data_s;
    logic              grant_we_s;

    // Arbitration: pick a requester in IDLE unless a clear is being requested
    always_comb begin
        grant_any_s = 1'b0;
        grant_sel_s = 1'b0;
        if ((state_r == ST_IDLE) && !clr_start) begin
            if (req0_valid && req1_valid) begin
                grant_any_s = 1'b1;
                grant_sel_s = prio_r;
            end else if (req0_valid) begin
                grant_any_s = 1'b1;
                grant_sel_s = 1'b0;
            end else if (req1_valid) begin
                grant_any_s = 1'b1;
                grant_sel_s = 1'b1;
            end else begin
                grant_any_s = 1'b0;
                grant_sel_s = 1'b0;
            end
        end else begin
            grant_any_s = 1'b0;
            grant_sel_s = 1'b0;
        end
    end

    // Mux the granted request and decide whether it actually writes
    always_comb begin
        grant_addr_s = req0_addr;
        grant_data_s = req0_data;
        grant_we_s   = 1'b1;
        if (grant_sel_s) begin
            grant_addr_s = req1_addr;
            grant_data_s = req1_data;
        end else begin
            grant_addr_s = req0_addr;
            grant_data_s = req0_data;
        end
        // Address 0 is hard-wired zero in the register file; suppress the strobe
        if ((ZERO_PROTECT != 0) && (grant_addr_s == {ADDR_W{1'b0}})) begin
            grant_we_s = 1'b0;
        end else begin
            grant_we_s = 1'b1;
        end
    end

    // Ready is forced low while reset is held so nothing is consumed
    assign req0_ready = !reset && grant_any_s && !grant_sel_s;
    assign req1_ready = !reset && grant_any_s &&  grant_sel_s;

    // Control state, round-robin pointer, clear counter and write-port flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            prio_r    <= 1'b0;
            clr_cnt_r <= {ADDR_W{1'b0}};
            busy      <= 1'b0;
            regWrite  <= 1'b0;
            Rw        <= {ADDR_W{1'b0}};
            W         <= {DATA_W{1'b0}};
            grant_id  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clr_start) begin
                        // The start edge already issues the write for address 0
                        state_r   <= ST_CLEAR;
                        busy      <= 1'b1;
                        regWrite  <= 1'b1;
                        Rw        <= {ADDR_W{1'b0}};
                        W         <= {DATA_W{1'b0}};
                        grant_id  <= 1'b0;
                        clr_cnt_r <= ADDR_W'(1);
                    end else begin
                        busy <= 1'b0;
                        if (grant_any_s) begin
                            regWrite <= grant_we_s;
                            Rw       <= grant_addr_s;
                            W        <= grant_data_s;
                            grant_id <= grant_sel_s;
                            // Whoever was not served gets priority next time
                            prio_r   <= ~grant_sel_s;
                        end else begin
                            regWrite <= 1'b0;
                        end
                    end
                end
                ST_CLEAR: begin
                    busy     <= 1'b1;
                    regWrite <= 1'b1;
                    Rw       <= clr_cnt_r;
                    W        <= {DATA_W{1'b0}};
                    grant_id <= 1'b0;
                    // Leave on the edge that issues the last address so the
                    // next edge can already accept a request
                    if (clr_cnt_r == {ADDR_W{1'b1}}) begin
                        state_r   <= ST_IDLE;
                        clr_cnt_r <= {ADDR_W{1'b0}};
                    end else begin
                        clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    clr_cnt_r <= {ADDR_W{1'b0}};
                    busy      <= 1'b0;
                    regWrite  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// transaction-level reference model. Two instances run in lockstep, one with
// address-0 protection and one without.
module tb_regfile_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NREG = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_data = '0;
    logic          req1_valid = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_data = '0;
    logic          clr_start = 1'b0;

    logic          r0_ready, r1_ready, busy, regWrite, grant_id;
    logic [AW-1:0] Rw;
    logic [DW-1:0] W;
    logic          n_r0_ready, n_r1_ready, n_busy, n_regWrite, n_grant_id;
    logic [AW-1:0] n_Rw;
    logic [DW-1:0] n_W;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ZERO_PROTECT(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(r0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(r1_ready),
        .clr_start(clr_start), .busy(busy), .regWrite(regWrite), .Rw(Rw), .W(W), .grant_id(grant_id)
    );

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ZERO_PROTECT(0)) dut_np (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(n_r0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(n_r1_ready),
        .clr_start(clr_start), .busy(n_busy), .regWrite(n_regWrite), .Rw(n_Rw), .W(n_W), .grant_id(n_grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_prio = 0;     // requester favoured on contention
    int            m_left = 0;     // clear writes still to issue
    int            m_next = 0;     // next clear address
    logic          e_busy = 1'b0;
    logic          e_we = 1'b0;    // expected regWrite, protected instance
    logic          e_we_np = 1'b0; // expected regWrite, unprotected instance
    logic [AW-1:0] e_rw = '0;
    logic [DW-1:0] e_w = '0;
    logic          e_gid = 1'b0;
    logic          acc0 = 1'b0;    // requester accepted at the last edge
    logic          acc1 = 1'b0;

    function automatic logic exp_ready(input int idx);
        if (reset || m_left != 0 || clr_start) return 1'b0;
        if (req0_valid && req1_valid) return (m_prio == idx);
        if (idx == 0) return req0_valid;
        return req1_valid;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_prio <= 0; m_left <= 0; m_next <= 0;
            e_busy <= 1'b0; e_we <= 1'b0; e_we_np <= 1'b0;
            e_rw <= '0; e_w <= '0; e_gid <= 1'b0;
            acc0 <= 1'b0; acc1 <= 1'b0;
        end else begin
            acc0 <= exp_ready(0);
            acc1 <= exp_ready(1);
            if (m_left > 0) begin
                e_rw <= AW'(m_next); m_next <= m_next + 1; m_left <= m_left - 1;
                e_busy <= 1'b1; e_we <= 1'b1; e_we_np <= 1'b1; e_w <= '0; e_gid <= 1'b0;
            end else if (clr_start) begin
                e_rw <= '0; m_next <= 1; m_left <= NREG - 1;
                e_busy <= 1'b1; e_we <= 1'b1; e_we_np <= 1'b1; e_w <= '0; e_gid <= 1'b0;
            end else begin
                e_busy <= 1'b0;
                if (exp_ready(0)) begin
                    e_rw <= req0_addr; e_w <= req0_data; e_gid <= 1'b0;
                    e_we <= (req0_addr != 0); e_we_np <= 1'b1; m_prio <= 1;
                end else if (exp_ready(1)) begin
                    e_rw <= req1_addr; e_w <= req1_data; e_gid <= 1'b1;
                    e_we <= (req1_addr != 0); e_we_np <= 1'b1; m_prio <= 0;
                end else begin
                    e_we <= 1'b0; e_we_np <= 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("ready0",   64'(r0_ready),   64'(exp_ready(0)));
        chk("ready1",   64'(r1_ready),   64'(exp_ready(1)));
        chk("busy",     64'(busy),       64'(e_busy));
        chk("regWrite", 64'(regWrite),   64'(e_we));
        chk("Rw",       64'(Rw),         64'(e_rw));
        chk("W",        64'(W),          64'(e_w));
        chk("grant_id", 64'(grant_id),   64'(e_gid));
        chk("np_ready0",   64'(n_r0_ready), 64'(exp_ready(0)));
        chk("np_ready1",   64'(n_r1_ready), 64'(exp_ready(1)));
        chk("np_busy",     64'(n_busy),     64'(e_busy));
        chk("np_regWrite", 64'(n_regWrite), 64'(e_we_np));
        chk("np_Rw",       64'(n_Rw),       64'(e_rw));
        chk("np_W",        64'(n_W),        64'(e_w));
        chk("np_grant_id", 64'(n_grant_id), 64'(e_gid));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        #2 reset = 1'b0;
    endtask

    initial begin
        int n0, n1;
        logic p0, p1;

        #1 reset = 1'b1;
        @(negedge clk);
        chk("lit_reset_regWrite", 64'(regWrite), 64'd0);
        chk("lit_reset_busy",     64'(busy),     64'd0);
        chk("lit_reset_ready0",   64'(r0_ready), 64'd0);
        tick();
        #2 reset = 1'b0;

        // Single request
        tick();
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("lit_single_ready", 64'(r0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("lit_single_we",  64'(regWrite), 64'd1);
        chk("lit_single_Rw",  64'(Rw),       64'd3);
        chk("lit_single_W",   64'(W),        64'hDEADBEEF);
        chk("lit_single_gid", 64'(grant_id), 64'd0);
        tick();
        @(negedge clk);
        chk("lit_single_idle", 64'(regWrite), 64'd0);

        // Contention from a fresh reset (prio = 0)
        do_reset();
        tick();
        n0 = 0; n1 = 0;
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h100;
        req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'h200;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (acc0) n0++;
            if (acc1) n1++;
            req0_data = 32'h100 + DW'(n0);
            req1_data = 32'h200 + DW'(n1);
            @(negedge clk);
            chk("lit_cont_gid", 64'(grant_id), 64'(c % 2));
            chk("lit_cont_W",   64'(W), (c % 2 == 0) ? 64'(32'h100 + c / 2) : 64'(32'h200 + c / 2));
            chk("lit_cont_we",  64'(regWrite), 64'd1);
        end
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Zero protect
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h5;
        @(negedge clk);
        chk("lit_zp_ready", 64'(r1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("lit_zp_we",    64'(regWrite),   64'd0);
        chk("lit_np_we",    64'(n_regWrite), 64'd1);
        chk("lit_np_Rw",    64'(n_Rw),       64'd0);
        chk("lit_np_W",     64'(n_W),        64'h5);

        // Clear sweep with a pending request and a re-pulse mid-sweep
        tick();
        clr_start = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
        @(negedge clk);
        chk("lit_clr_ready_pre", 64'(r0_ready), 64'd0);
        tick();
        clr_start = 1'b0;
        for (int j = 0; j < NREG; j++) begin
            if (j == 10) clr_start = 1'b1;
            if (j == 11) clr_start = 1'b0;
            @(negedge clk);
            chk("lit_clr_Rw",    64'(Rw),       64'(j));
            chk("lit_clr_W",     64'(W),        64'd0);
            chk("lit_clr_busy",  64'(busy),     64'd1);
            chk("lit_clr_we",    64'(regWrite), 64'd1);
            chk("lit_clr_ready", 64'(r0_ready), (j == NREG - 1) ? 64'd1 : 64'd0);
            tick();
        end
        req0_valid = 1'b0;
        @(negedge clk);
        chk("lit_after_clr_we",   64'(regWrite), 64'd1);
        chk("lit_after_clr_Rw",   64'(Rw),       64'd7);
        chk("lit_after_clr_W",    64'(W),        64'h77);
        chk("lit_after_clr_busy", 64'(busy),     64'd0);

        // Reset in the middle of a sweep
        tick();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (17) tick();
        @(negedge clk);
        chk("lit_mid_Rw", 64'(Rw), 64'd17);
        #1 reset = 1'b1;
        #1;
        chk("lit_abort_busy", 64'(busy),     64'd0);
        chk("lit_abort_we",   64'(regWrite), 64'd0);
        chk("lit_abort_Rw",   64'(Rw),       64'd0);
        chk("lit_abort_W",    64'(W),        64'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
        @(negedge clk);
        chk("lit_post_reset_ready", 64'(r1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("lit_post_reset_we",  64'(regWrite), 64'd1);
        chk("lit_post_reset_Rw",  64'(Rw),       64'd9);
        chk("lit_post_reset_gid", 64'(grant_id), 64'd1);

        // Randomized traffic, requesters obey the hold-until-ready rule
        p0 = 1'b0; p1 = 1'b0;
        tick();
        repeat (800) begin
            tick();
            if (acc0) p0 = 1'b0;
            if (acc1) p1 = 1'b0;
            if (!p0 && ($urandom % 3 == 0)) begin
                p0 = 1'b1;
                req0_addr = ($urandom % 4 == 0) ? 5'd0 : AW'($urandom);
                req0_data = $urandom;
            end
            if (!p1 && ($urandom % 3 == 0)) begin
                p1 = 1'b1;
                req1_addr = ($urandom % 4 == 0) ? 5'd0 : AW'($urandom);
                req1_data = $urandom;
            end
            req0_valid = p0;
            req1_valid = p1;
            clr_start  = ($urandom % 90 == 0);
        end
        clr_start = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two writeback requesters, for example the ALU path and a multi-cycle unit, using round-robin arbitration and valid/ready handshakes. It also runs a sequenced software clear that zeroes every register, one per cycle. It sits between the writeback sources and the register file's regWrite/Rw/W inputs. All write-port outputs are registered.

## Interface
- DATA_W, 32, data width of W and request data
- ADDR_W, 5, register address width; the clear sweep covers 2^ADDR_W entries
- ZERO_PROTECT, 1, when 1, accepted requests to address 0 are consumed but do not assert regWrite

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req0_valid  in  1  requester 0 has a write pending
- req0_addr  in  ADDR_W  requester 0 destination register
- req0_data  in  DATA_W  requester 0 write data
- req0_ready  out  1  requester 0 accepted this cycle (combinational)
- req1_valid, req1_addr, req1_data, req1_ready  same as requester 0, for requester 1
- clr_start  in  1  start a clear sweep (level, sampled in IDLE)
- busy  out  1  clear sweep in progress
- regWrite  out  1  write strobe to the register file
- Rw  out  ADDR_W  write address
- W  out  DATA_W  write data
- grant_id  out  1  requester whose data is on W; 0 during clear

## Operation
- Reset values:
  - state IDLE, prio=0, clear counter 0
  - busy=0, regWrite=0, Rw=0, W=0, grant_id=0
  - ready outputs 0 while reset is high
- States:
  - IDLE: arbitrate requests; clr_start=1 moves to CLEAR.
  - CLEAR: sweep the clear counter; after the last address, return to IDLE.
- Handshake: a transfer occurs when valid && ready at a rising edge. A requester holds valid, addr and data stable until its ready is seen.
- Ready (combinational):
  - Both ready=0 in CLEAR.
  - Both ready=0 in IDLE when clr_start=1, because clear wins over requests.
  - Otherwise: only one valid means that requester is ready; both valid means the requester selected by prio is ready.
- Round-robin:
  - On a contended grant, prio moves to the loser.
  - On an uncontended grant, prio moves to the requester that was not granted.
  - prio is unchanged in cycles with no grant.
- Write issue:
  - On a transfer edge, Rw/W/grant_id load from the granted request.
  - regWrite=1, except regWrite=0 when addr==0 and ZERO_PROTECT=1.
  - With no transfer: regWrite=0, and Rw/W/grant_id hold their last values.
- CLEAR sweep:
  - The counter i runs 0..2^ADDR_W-1.
  - Each edge issues regWrite=1, Rw=i, W=0, grant_id=0, including address 0.
  - Requests stay pending untouched and resume arbitration in IDLE with the prio held from before the clear.
- clr_start during CLEAR is ignored; a sweep is never restarted or extended.
- Reset mid-sweep aborts immediately to reset values; no partial state survives.

## Timing
- Write latency: handshake at edge N gives regWrite/Rw/W valid in the cycle after edge N, and the register file writes at edge N+1.
- Throughput: one write per cycle, back-to-back grants allowed.
- Clear timing:
  - clr_start sampled at edge k.
  - Edges k..k+2^ADDR_W-1 present Rw=0..2^ADDR_W-1.
  - busy=1 from edge k until edge k+2^ADDR_W, at which point regWrite=0 and state is IDLE.
  - Earliest request accept is at edge k+2^ADDR_W; with defaults, 32 clear writes followed by a first request write visible after edge k+32.
- Fairness bound: under continuous contention, each requester waits at most 1 cycle between grants.

## Test plan
- Single request: req0 addr=3 data=0xDEADBEEF for one cycle -> req0_ready=1 that cycle; next cycle regWrite=1, Rw=3, W=0xDEADBEEF, grant_id=0; then regWrite=0.
- Contention: both valid continuously for 6 cycles with prio=0 after reset -> grants 0,1,0,1,0,1; each requester's data appears on W in order; no cycle without a write.
- Zero protect: req1 addr=0 data=0x5 -> req1_ready=1, then regWrite=0; with ZERO_PROTECT=0 -> regWrite=1, Rw=0.
- Clear with pending request:
  - clr_start=1 while req0 is valid -> req0_ready=0 for 32 cycles.
  - Rw steps 0..31 with W=0 and busy=1 throughout; clr_start re-pulsed mid-sweep has no effect.
  - req0 is then accepted at the first IDLE edge.
- Reset mid-sweep: assert reset at Rw=17 -> busy, regWrite, Rw and W are all 0 at once, asynchronously; after release, state is IDLE and a new request is accepted in the first cycle.
